// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// A character FIFO feeds a start/data/parity/stop shifter.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] data,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity,
  input  logic              stop2,
  output logic              serialOut,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  state_t            state;
  state_t            state_d;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        par_q;
  logic              stop2_q;
  logic              par_bit;
  logic [DATA_W-1:0] sh;
  logic [2:0]        bitn;
  logic              tick;
  logic              line_d;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign busy  = (state != IDLE);
  assign push  = wr & ~full;
  assign tick  = (cnt == div_q);
  assign head  = mem[rptr];

  // character storage; pointers make stale entries invisible
  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wptr] <= data;
  end

  // fifo pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
      if (wr && full)
        overflow <= 1'b1;
    end
  end

  // frame state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  // next state, pop request and line level
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    line_d  = 1'b1;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        line_d = 1'b0;
        if (tick)
          state_d = DATA;
      end
      DATA: begin
        line_d = sh[0];
        if (tick && bitn == 3'(DATA_W-1))
          state_d = (^par_q) ? PARITY : STOP;
      end
      PARITY: begin
        line_d = par_bit;
        if (tick)
          state_d = STOP;
      end
      STOP: begin
        if (tick && (bitn[0] || !stop2_q)) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // baud/bit counters, shifter, per-frame settings, line register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      div_q     <= '0;
      par_q     <= '0;
      stop2_q   <= 1'b0;
      par_bit   <= 1'b0;
      serialOut <= 1'b1;
    end else begin
      serialOut <= line_d;
      if (pop) begin
        cnt     <= '0;
        bitn    <= '0;
        sh      <= head;
        div_q   <= baud_div;
        par_q   <= parity;
        stop2_q <= stop2;
        par_bit <= (^head) ^ parity[1];
      end else if (state != IDLE) begin
        cnt <= tick ? '0 : cnt + DIV_W'(1);
        if (state_d != state)
          bitn <= '0;
        else if (tick)
          bitn <= bitn + 3'd1;
        if (state == DATA && tick)
          sh <= sh >> 1;
      end
    end
  end

endmodule
